// File: rtl/mxv_scheduler_if.sv
// Port bundle for the matrix-vector scheduler: command inputs, matrix/vector
// RAM read ports, result FIFO write side, status pulses and FSM debug state.
interface mxv_scheduler_if #(
  parameter int MAX_N  = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W + $clog2(MAX_N)
);
  localparam int MAW = $clog2(MAX_N*MAX_N);
  localparam int VAW = $clog2(MAX_N);
  localparam int SW  = $clog2(MAX_N+1);

  logic              start;
  logic              clear;
  logic [SW-1:0]     size;
  logic [MAW-1:0]    mat_addr;
  logic [DATA_W-1:0] mat_data;
  logic [VAW-1:0]    vec_addr;
  logic [DATA_W-1:0] vec_data;
  // FIFO write handshake: fifo_push is the valid strobe and !fifo_full the
  // ready; a row sum transfers only in a cycle where both are true, and
  // fifo_data holds its value for as long as the write is stalled.
  logic              fifo_push;
  logic [ACC_W-1:0]  fifo_data;
  logic              fifo_full;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        state_dbg;

  modport master (
    input  start, clear, size, mat_data, vec_data, fifo_full,
    output mat_addr, vec_addr, fifo_push, fifo_data, busy, done, err, state_dbg
  );
  modport slave (
    output start, clear, size, mat_data, vec_data, fifo_full,
    input  mat_addr, vec_addr, fifo_push, fifo_data, busy, done, err, state_dbg
  );
endinterface

// File: rtl/mxv_scheduler.sv
// Walks an N x N matrix and N-vector row by row through one MAC and pushes
// each row sum into the result FIFO.
module mxv_scheduler #(
  parameter int MAX_N  = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W + $clog2(MAX_N)
) (
  input logic           clk,
  input logic           reset,
  mxv_scheduler_if.master bus
);
  localparam int RW  = $clog2(MAX_N);
  localparam int SW  = $clog2(MAX_N+1);
  localparam int MAW = $clog2(MAX_N*MAX_N);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    PUSH  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state, state_d;
  logic [SW-1:0]       n_reg, n_reg_d;
  logic [RW-1:0]       row, row_d, col, col_d;
  logic [ACC_W-1:0]    acc;
  logic                rd_valid;
  logic                err_d;
  logic                size_ok, last_col, last_row;
  logic [2*DATA_W-1:0] product;
  logic [MAW-1:0]      mat_addr_q;
  logic [RW-1:0]       vec_addr_q;
  logic                busy_q, done_q, err_q;

  assign size_ok  = (bus.size != '0) && (bus.size <= SW'(MAX_N));
  assign last_col = (SW'(col) == n_reg - SW'(1));
  assign last_row = (SW'(row) == n_reg - SW'(1));
  assign product  = bus.mat_data * bus.vec_data;

  always_comb begin
    state_d = state;
    n_reg_d = n_reg;
    row_d   = row;
    col_d   = col;
    err_d   = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      row_d   = '0;
      col_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            n_reg_d = bus.size;
            if (size_ok) begin
              state_d = ISSUE;
              row_d   = '0;
              col_d   = '0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ISSUE: begin
          if (last_col) state_d = DRAIN;
          else          col_d   = col + RW'(1);
        end
        DRAIN: state_d = PUSH;
        PUSH: begin
          // A stalled write simply waits here with acc untouched.
          if (!bus.fifo_full) begin
            if (last_row) begin
              state_d = DONE;
            end else begin
              state_d = ISSUE;
              row_d   = row + RW'(1);
              col_d   = '0;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          row_d   = '0;
          col_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      n_reg      <= '0;
      row        <= '0;
      col        <= '0;
      acc        <= '0;
      rd_valid   <= 1'b0;
      mat_addr_q <= '0;
      vec_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state    <= state_d;
      n_reg    <= n_reg_d;
      row      <= row_d;
      col      <= col_d;
      // Read data lags the issued address by one cycle.
      rd_valid <= (state == ISSUE) && !bus.clear;
      if (bus.clear)                         acc <= '0;
      else if (state == ISSUE && col == '0)  acc <= '0;
      else if (rd_valid)                     acc <= acc + ACC_W'(product);
      if (state_d == ISSUE) begin
        mat_addr_q <= MAW'(row_d) * MAW'(MAX_N) + MAW'(col_d);
        vec_addr_q <= col_d;
      end else begin
        mat_addr_q <= '0;
        vec_addr_q <= '0;
      end
      busy_q <= (state_d == ISSUE) || (state_d == DRAIN) || (state_d == PUSH);
      done_q <= (state_d == DONE);
      err_q  <= err_d;
    end
  end

  assign bus.mat_addr  = mat_addr_q;
  assign bus.vec_addr  = vec_addr_q;
  assign bus.fifo_push = (state == PUSH) && !bus.fifo_full && !bus.clear;
  assign bus.fifo_data = acc;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_mxv_scheduler.sv
// Directed bench for mxv_scheduler: table of runs plus hand sequences for
// illegal sizes, ignored restart, clear and reset mid-run.
module tb_mxv_scheduler;
  localparam int MAX_N  = 8;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 19;

  logic clk = 1'b0;
  logic reset;

  mxv_scheduler_if #(.MAX_N(MAX_N), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  mxv_scheduler #(.MAX_N(MAX_N), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mat_mem [64];
  logic [DATA_W-1:0] vec_mem [8];

  always @(posedge clk) begin
    bus.mat_data <= mat_mem[bus.mat_addr];
    bus.vec_data <= vec_mem[bus.vec_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [ACC_W-1:0] exp_q[$];
  int               cyc_q[$];

  typedef struct {
    string       name;
    int          n;
    int          kind;
    int          stall_from;
    int          stall_to;
    logic [31:0] exp_first;
    int          exp_done;
  } case_t;

  case_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_mem(input int kind);
    for (int i = 0; i < 64; i++) mat_mem[i] = '0;
    for (int i = 0; i < 8; i++)  vec_mem[i] = '0;
    case (kind)
      0: begin
        mat_mem[0] = 8'd1; mat_mem[1] = 8'd2; mat_mem[8] = 8'd3; mat_mem[9] = 8'd4;
        vec_mem[0] = 8'd5; vec_mem[1] = 8'd6;
      end
      1: begin
        mat_mem[0] = 8'd7; vec_mem[0] = 8'd9;
      end
      2: begin
        for (int i = 0; i < 64; i++) mat_mem[i] = 8'hFF;
        for (int i = 0; i < 8; i++)  vec_mem[i] = 8'hFF;
      end
      default: begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) mat_mem[r*8+c] = 8'(r*3 + c + 1);
        vec_mem[0] = 8'd1; vec_mem[1] = 8'd2; vec_mem[2] = 8'd3;
      end
    endcase
  endtask

  // Expected row sums and push cycles; a stalled PUSH slips everything after it.
  task automatic build_expect(input int n, input int sf, input int st);
    int t;
    logic [31:0] s;
    exp_q.delete();
    cyc_q.delete();
    t = 0;
    for (int r = 0; r < n; r++) begin
      s = 0;
      for (int c = 0; c < n; c++) s += 32'(mat_mem[r*8+c]) * 32'(vec_mem[c]);
      exp_q.push_back(s[ACC_W-1:0]);
      t = t + n + 2;
      while (t >= sf && t <= st) t++;
      cyc_q.push_back(t);
    end
  endtask

  task automatic run(input string name, input int n, input int sf, input int st,
                     input logic [31:0] exp_first, input int exp_done, input int ign);
    int cyc, got_done, busy_cnt, pushes;
    logic [31:0] first;
    got_done = -1; busy_cnt = 0; pushes = 0; first = '1;
    @(negedge clk);
    bus.size  = 4'(n);
    bus.start = 1'b1;
    cyc = 1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < 300 && got_done < 0) begin
      bus.fifo_full = (cyc >= sf && cyc <= st);
      bus.start     = (cyc == ign);
      if (cyc == ign) bus.size = 4'd1;
      #1;
      if (bus.fifo_full && exp_q.size() > 0)
        check({name, "_held_data"}, 32'(bus.fifo_data), 32'(exp_q[0]));
      if (bus.fifo_push) begin
        pushes++;
        if (pushes == 1) first = 32'(bus.fifo_data);
        if (exp_q.size() == 0) begin
          check({name, "_extra_push"}, 32'(cyc), 32'(-1));
        end else begin
          check({name, "_push_data"}, 32'(bus.fifo_data), 32'(exp_q.pop_front()));
          check({name, "_push_cycle"}, 32'(cyc), 32'(cyc_q.pop_front()));
        end
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) got_done = cyc;
      @(negedge clk);
      cyc++;
    end
    bus.fifo_full = 1'b0;
    bus.start     = 1'b0;
    check({name, "_done_cycle"}, 32'(got_done), 32'(exp_done));
    check({name, "_push_count"}, 32'(pushes), 32'(n));
    check({name, "_first_sum"}, first, exp_first);
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_done - 1));
  endtask

  task automatic err_case(input string name, input int sz);
    int pushes, busy_seen, errs;
    pushes = 0; busy_seen = 0; errs = 0;
    @(negedge clk);
    bus.size  = 4'(sz);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check({name, "_err_cycle1"}, 32'(bus.err), 32'd1);
    check({name, "_busy_cycle1"}, 32'(bus.busy), 32'd0);
    for (int k = 2; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (bus.fifo_push) pushes++;
      if (bus.busy) busy_seen++;
      if (bus.err) errs++;
    end
    check({name, "_no_push"}, 32'(pushes), 32'd0);
    check({name, "_busy_low"}, 32'(busy_seen), 32'd0);
    check({name, "_err_single"}, 32'(errs), 32'd0);
  endtask

  // Start an N=3 run and abort it in cycle 6 by clear (mode 0) or reset (mode 1).
  task automatic abort_case(input string name, input int mode);
    int pushes, dones;
    pushes = 0; dones = 0;
    fill_mem(3);
    @(negedge clk);
    bus.size  = 4'd3;
    bus.start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    if (mode == 0) begin
      bus.clear = 1'b1;
      #1;
      if (bus.fifo_push) pushes++;
    end else begin
      reset = 1'b0;
      #1;
      check({name, "_busy_in_reset"}, 32'(bus.busy), 32'd0);
      check({name, "_state_in_reset"}, 32'(bus.state_dbg), 32'd0);
      check({name, "_data_in_reset"}, 32'(bus.fifo_data), 32'd0);
    end
    @(negedge clk);
    bus.clear = 1'b0;
    reset     = 1'b1;
    #1;
    check({name, "_state_idle"}, 32'(bus.state_dbg), 32'd0);
    check({name, "_busy_low"}, 32'(bus.busy), 32'd0);
    check({name, "_addr_zero"}, 32'(bus.mat_addr), 32'd0);
    check({name, "_acc_zero"}, 32'(bus.fifo_data), 32'd0);
    for (int k = 0; k < 12; k++) begin
      if (bus.fifo_push) pushes++;
      if (bus.done) dones++;
      @(negedge clk);
      #1;
    end
    check({name, "_no_push"}, 32'(pushes), 32'd0);
    check({name, "_no_done"}, 32'(dones), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mat_mem[i] = '0;
    for (int i = 0; i < 8; i++)  vec_mem[i] = '0;
    reset = 1'b0;
    bus.start = 1'b0; bus.clear = 1'b0; bus.size = '0; bus.fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mat_addr", 32'(bus.mat_addr), 32'd0);
    check("rst_vec_addr", 32'(bus.vec_addr), 32'd0);
    check("rst_fifo_push", 32'(bus.fifo_push), 32'd0);
    check("rst_fifo_data", 32'(bus.fifo_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    tbl[0] = '{"n2",       2, 0, -1, -1, 32'd17,     9};
    tbl[1] = '{"n1",       1, 1, -1, -1, 32'd63,     4};
    tbl[2] = '{"n8_ff",    8, 2, -1, -1, 32'd520200, 81};
    tbl[3] = '{"n2_stall", 2, 0,  4,  6, 32'd17,     12};
    tbl[4] = '{"n3",       3, 3, -1, -1, 32'd14,     16};
    for (int i = 0; i < 5; i++) begin
      fill_mem(tbl[i].kind);
      build_expect(tbl[i].n, tbl[i].stall_from, tbl[i].stall_to);
      run(tbl[i].name, tbl[i].n, tbl[i].stall_from, tbl[i].stall_to,
          tbl[i].exp_first, tbl[i].exp_done, -1);
    end

    err_case("size0", 0);
    err_case("size9", 9);

    fill_mem(0);
    build_expect(2, -1, -1);
    run("restart_ignored", 2, -1, -1, 32'd17, 9, 3);

    abort_case("clear", 0);
    fill_mem(0);
    build_expect(2, -1, -1);
    run("after_clear", 2, -1, -1, 32'd17, 9, -1);

    abort_case("reset", 1);
    fill_mem(0);
    build_expect(2, -1, -1);
    run("after_reset", 2, -1, -1, 32'd17, 9, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mxv_scheduler.md
# mxv_scheduler

Sequencer for the matrix-vector multiply datapath behind the UART command controller. On a start pulse it walks the stored N×N matrix and N-element vector, row by row, through a single multiply-accumulate unit. Each finished row sum is pushed into the result FIFO, which the UART control block later drains in a 0xFE / length / data / 0xEF frame. The UART controller owns loading the matrix, vector and size; this block owns only computation scheduling.

## Interface
- MAX_N, 8, maximum matrix dimension; matrix RAM row stride
- DATA_W, 8, element width (unsigned)
- ACC_W, 2*DATA_W+$clog2(MAX_N) = 19, accumulator / result width
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  one-cycle pulse, begin computation
- clear  in  1  synchronous abort to IDLE, no done
- size  in  4  N, legal 1..MAX_N, sampled only with start
- mat_addr  out  6  matrix RAM read address = row*MAX_N + col
- mat_data  in  DATA_W  matrix RAM read data, valid 1 cycle after address
- vec_addr  out  3  vector RAM read address = col
- vec_data  in  DATA_W  vector RAM read data, valid 1 cycle after address
- fifo_push  out  1  write strobe to result FIFO
- fifo_data  out  ACC_W  row sum
- fifo_full  in  1  result FIFO cannot accept a write
- busy  out  1  computation in progress
- done  out  1  one-cycle pulse, all N rows pushed
- err  out  1  one-cycle pulse, start with illegal size

## Operation
- States: IDLE, ISSUE, DRAIN, PUSH, DONE.
- IDLE, start=1: latch size into n_reg.
  - size==0 or size>MAX_N: err=1 next cycle, stay IDLE.
  - Otherwise: row=0, col=0, go ISSUE.
- ISSUE:
  - Drive mat_addr/vec_addr for (row, col), col++ each cycle.
  - acc cleared on col==0 issue cycle.
  - Leave for DRAIN after issuing col==n_reg-1.
- Accumulate: rd_valid is a 1-cycle-delayed copy of the issue strobe. When rd_valid=1, acc += mat_data*vec_data (unsigned, full-width product zero-extended to ACC_W). No overflow possible at MAX_N.
- DRAIN: one cycle, absorbs the last product.
- PUSH:
  - fifo_data=acc (held stable). fifo_push=!fifo_full.
  - fifo_full=1: stay in PUSH, no push.
  - On push with row<n_reg-1: row++, col=0, go ISSUE.
  - On push with last row: go DONE.
- DONE: done=1 for one cycle, go IDLE.
- busy=1 in ISSUE, DRAIN, PUSH; 0 in IDLE and DONE.
- start outside IDLE is ignored.
- clear in any state: next cycle IDLE, counters and acc zeroed, no push, no done; clear has priority over start.
- Addresses are 0 outside ISSUE.

## Timing
- Reset: state IDLE; mat_addr, vec_addr, fifo_push, fifo_data, busy, done, err, acc, row, col all 0.
- start sampled in cycle 0:
  - Row r issues in cycles r*(N+2)+1 .. r*(N+2)+N.
  - DRAIN occurs at r*(N+2)+N+1.
  - PUSH occurs at r*(N+2)+N+2 when fifo_full=0.
  - done occurs at N*(N+2)+1 with no backpressure.
- Each cycle of fifo_full=1 during PUSH delays all subsequent events by 1.
- fifo_push is combinational from state and fifo_full; all other outputs are registered.
- err is asserted in cycle 1 when the size is illegal; busy stays 0.
- Reset mid-operation: immediate return to reset values; no partial push completes.

## Test plan
- N=2, M=[[1,2],[3,4]], v=[5,6], fifo_full=0 -> pushes 17 at cycle 4 and 39 at cycle 8, done at cycle 9, busy high cycles 1–8.
- N=1, M=[[7]], v=[9] -> single push of 63 at cycle 3, done at cycle 4.
- N=8, all elements 0xFF -> eight pushes of 520200, done at cycle 81.
- N=2, fifo_full held high cycles 4–6 -> first push at cycle 7 with 17 held on fifo_data cycles 4–7, done at cycle 12.
- size=0 and size=9 starts -> err pulse at cycle 1, no push, busy stays 0; a start at cycle 3 of an active N=2 run is ignored.
- N=3 run with clear at cycle 6, and separately reset low at cycle 6 -> no push, no done, IDLE next cycle; a fresh N=2 start then yields correct results.
